// File: rtl/ascon_share_pkg.sv
// Shared definitions for the Ascon threshold-implementation front-end:
// controller states, PRNG lane constants, xorshift64 step and width helpers.
package ascon_share_pkg;

  typedef enum logic [2:0] {
    ST_UNSEEDED,
    ST_READY,
    ST_FILL,
    ST_START,
    ST_BUSY,
    ST_RELEASE,
    ST_RESULT
  } state_t;

  localparam int          NUM_LANES = 8;
  localparam logic [63:0] LANE_C0   = 64'h9E3779B97F4A7C15;

  // Lane i constant is C0 rotated left by 8*i bits.
  function automatic logic [63:0] lane_const(input int i);
    logic [127:0] d;
    d = {LANE_C0, LANE_C0} << (8 * i);
    return d[127:64];
  endfunction

  // One xorshift64 step: x ^= x<<13; x ^= x>>7; x ^= x<<17.
  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] v;
    v = x ^ (x << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  // Total share-random bits: two shares each of key, nonce, AD and PT.
  function automatic int calc_rb(input int k, input int l, input int y);
    return 2 * (k + 128 + l + y);
  endfunction

  // Number of 64-bit words needed to cover rb bits.
  function automatic int calc_w(input int rb);
    return (rb + 63) / 64;
  endfunction

endpackage

// File: rtl/ascon_share_ctrl_lane.sv
// One xorshift64 PRNG lane with seed load and step enable.
module ascon_xorshift_lane
  import ascon_share_pkg::*;
#(
  parameter logic [63:0] C = 64'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] state
);

  logic [63:0] seeded_val;

  // A seed that would cancel the lane constant falls back to the constant,
  // so the lane never lands in the all-zero fixed point.
  assign seeded_val = seed ^ C;

  // Lane state: seed load has priority over stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= C;
    end else if (load) begin
      state <= (seeded_val == '0) ? C : seeded_val;
    end else if (step) begin
      state <= xs_step(state);
    end
  end

endmodule

// File: rtl/ascon_share_ctrl.sv
// Front-end and result collector for the 3-share Ascon AEAD core: latches a
// request, fills masking shares from PRNG lane 0, pulses start, collects result.
module ascon_share_ctrl
  import ascon_share_pkg::*;
#(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seed_valid,
  input  logic [63:0]    seed,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [K-1:0]   req_key,
  input  logic [127:0]   req_nonce,
  input  logic [L-1:0]   req_ad,
  input  logic [Y-1:0]   req_pt,
  output logic [K-1:0]   key,
  output logic [127:0]   nonce,
  output logic [L-1:0]   associated_data,
  output logic [Y-1:0]   plain_text,
  output logic [K-1:0]   random_key_1,
  output logic [K-1:0]   random_key_2,
  output logic [127:0]   random_nonce_1,
  output logic [127:0]   random_nonce_2,
  output logic [L-1:0]   random_ad_1,
  output logic [L-1:0]   random_ad_2,
  output logic [Y-1:0]   random_pt_1,
  output logic [Y-1:0]   random_pt_2,
  output logic [63:0]    r0,
  output logic [63:0]    r1,
  output logic [63:0]    r2,
  output logic [63:0]    r3,
  output logic [63:0]    r4,
  output logic [63:0]    r5,
  output logic [63:0]    r6,
  output logic           encryption_start,
  input  logic           encryption_ready,
  input  logic [Y-1:0]   cipher_text,
  input  logic [127:0]   tag,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [Y-1:0]   res_ct,
  output logic [127:0]   res_tag
);

  localparam int RB  = calc_rb(K, L, Y);
  localparam int W   = calc_w(RB);
  localparam int TOP = W * 64;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] FILL_LAST = CW'(W - 1);

  state_t        state;
  logic          seeded;
  logic [CW-1:0] fill_ctr;
  logic [TOP-1:0] share_buf;
  logic [63:0]   lane_state [NUM_LANES];
  logic [63:0]   lane0_next;
  logic          seed_load;
  logic          accept;

  assign seed_load = seed_valid && (state == ST_UNSEEDED || state == ST_READY);

  // NOTE: req_ready is combinational from seed_valid so a same-cycle reseed
  // blocks the request in that very cycle; a registered version would be late.
  assign req_ready = (state == ST_READY) && !seed_valid;
  assign accept    = req_ready && req_valid;
  assign lane0_next = xs_step(lane_state[0]);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ascon_xorshift_lane #(.C(lane_const(i))) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (seed_load),
      .seed  (seed),
      .step  ((i == 0) ? (state == ST_FILL) : seeded),
      .state (lane_state[i])
    );
  end

  // Fresh randomness is held at zero until the PRNG has been seeded.
  assign r0 = seeded ? lane_state[1] : '0;
  assign r1 = seeded ? lane_state[2] : '0;
  assign r2 = seeded ? lane_state[3] : '0;
  assign r3 = seeded ? lane_state[4] : '0;
  assign r4 = seeded ? lane_state[5] : '0;
  assign r5 = seeded ? lane_state[6] : '0;
  assign r6 = seeded ? lane_state[7] : '0;

  // Share map, MSB first; the lowest TOP-RB bits of the buffer are spare.
  assign random_key_1   = share_buf[TOP-1 -: K];
  assign random_key_2   = share_buf[TOP-1-K -: K];
  assign random_nonce_1 = share_buf[TOP-1-2*K -: 128];
  assign random_nonce_2 = share_buf[TOP-1-2*K-128 -: 128];
  assign random_ad_1    = share_buf[TOP-1-2*K-256 -: L];
  assign random_ad_2    = share_buf[TOP-1-2*K-256-L -: L];
  assign random_pt_1    = share_buf[TOP-1-2*K-256-2*L -: Y];
  assign random_pt_2    = share_buf[TOP-1-2*K-256-2*L-Y -: Y];

  // Request latch and share buffer; the buffer shifts only while filling.
  always_ff @(posedge clk) begin
    if (rst) begin
      key             <= '0;
      nonce           <= '0;
      associated_data <= '0;
      plain_text      <= '0;
      share_buf       <= '0;
    end else begin
      if (accept) begin
        key             <= req_key;
        nonce           <= req_nonce;
        associated_data <= req_ad;
        plain_text      <= req_pt;
      end
      if (state == ST_FILL) begin
        share_buf <= {share_buf[TOP-65:0], lane0_next};
      end
    end
  end

  // Control FSM with registered start/result handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_UNSEEDED;
      seeded           <= 1'b0;
      fill_ctr         <= '0;
      encryption_start <= 1'b0;
      res_valid        <= 1'b0;
      res_ct           <= '0;
      res_tag          <= '0;
    end else begin
      if (seed_load) seeded <= 1'b1;
      case (state)
        ST_UNSEEDED: if (seed_valid) state <= ST_READY;
        ST_READY: begin
          if (accept) begin
            fill_ctr <= '0;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          fill_ctr <= fill_ctr + CW'(1);
          if (fill_ctr == FILL_LAST) begin
            encryption_start <= 1'b1;
            state            <= ST_START;
          end
        end
        ST_START: begin
          encryption_start <= 1'b0;
          state            <= ST_BUSY;
        end
        ST_BUSY: begin
          if (encryption_ready) begin
            res_ct           <= cipher_text;
            res_tag          <= tag;
            encryption_start <= 1'b1;
            state            <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          encryption_start <= 1'b0;
          res_valid        <= 1'b1;
          state            <= ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_READY;
          end
        end
        default: state <= ST_UNSEEDED;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_share_ctrl.sv
// Self-checking bench for ascon_share_ctrl with a stand-in core model and a
// result scoreboard checked by an independent monitor.
module tb_ascon_share_ctrl;

  localparam int K = 128;
  localparam int L = 40;
  localparam int Y = 40;
  localparam int W = 11;
  localparam logic [63:0] C0 = 64'h9E3779B97F4A7C15;

  typedef struct packed {
    logic [Y-1:0] ct;
    logic [127:0] tag;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seed_valid = 1'b0;
  logic [63:0] seed = '0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [K-1:0] req_key = '0;
  logic [127:0] req_nonce = '0;
  logic [L-1:0] req_ad = '0;
  logic [Y-1:0] req_pt = '0;
  logic [K-1:0] key;
  logic [127:0] nonce;
  logic [L-1:0] associated_data;
  logic [Y-1:0] plain_text;
  logic [K-1:0] random_key_1, random_key_2;
  logic [127:0] random_nonce_1, random_nonce_2;
  logic [L-1:0] random_ad_1, random_ad_2;
  logic [Y-1:0] random_pt_1, random_pt_2;
  logic [63:0] r0, r1, r2, r3, r4, r5, r6;
  logic encryption_start;
  logic encryption_ready;
  logic [Y-1:0] cipher_text;
  logic [127:0] tag;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [Y-1:0] res_ct;
  logic [127:0] res_tag;

  int n_checks = 0;
  int n_fail   = 0;
  res_t exp_q[$];
  logic [63:0] m_lane0;

  always #5 clk = ~clk;

  ascon_share_ctrl #(.K(K), .L(L), .Y(Y)) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_nonce(req_nonce), .req_ad(req_ad), .req_pt(req_pt),
    .key(key), .nonce(nonce), .associated_data(associated_data),
    .plain_text(plain_text),
    .random_key_1(random_key_1), .random_key_2(random_key_2),
    .random_nonce_1(random_nonce_1), .random_nonce_2(random_nonce_2),
    .random_ad_1(random_ad_1), .random_ad_2(random_ad_2),
    .random_pt_1(random_pt_1), .random_pt_2(random_pt_2),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6),
    .encryption_start(encryption_start), .encryption_ready(encryption_ready),
    .cipher_text(cipher_text), .tag(tag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_ct(res_ct), .res_tag(res_tag)
  );

  logic any_out;
  assign any_out = |{req_ready, key, nonce, associated_data, plain_text,
                     random_key_1, random_key_2, random_nonce_1, random_nonce_2,
                     random_ad_1, random_ad_2, random_pt_1, random_pt_2,
                     r0, r1, r2, r3, r4, r5, r6, encryption_start,
                     res_valid, res_ct, res_tag};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_step(input logic [63:0] x);
    logic [63:0] a, b;
    a = x ^ {x[50:0], 13'b0};
    b = a ^ {7'b0, a[63:7]};
    return b ^ {b[46:0], 17'b0};
  endfunction

  function automatic logic [63:0] ref_const(input int i);
    logic [63:0] c;
    c = C0;
    for (int j = 0; j < i; j++) c = {c[55:0], c[63:56]};
    return c;
  endfunction

  function automatic logic [63:0] ref_init(input logic [63:0] s, input int i);
    logic [63:0] v;
    v = s ^ ref_const(i);
    return (v == '0) ? ref_const(i) : v;
  endfunction

  function automatic logic [Y-1:0] fake_ct(input logic [Y-1:0] p);
    return p ^ 40'h5A5A5A5A5A;
  endfunction

  function automatic logic [127:0] fake_tag(input logic [127:0] k, input logic [127:0] n,
                                            input logic [L-1:0] a);
    return k ^ {n[63:0], n[127:64]} ^ {88'h0, a};
  endfunction

  // Stand-in core: busy a few cycles after start, DONE until the release pulse.
  typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} core_t;
  core_t cst;
  int    ccnt;
  always @(posedge clk) begin
    if (rst) begin
      cst <= C_IDLE;
      ccnt <= 0;
    end else begin
      case (cst)
        C_IDLE: if (encryption_start) begin cst <= C_BUSY; ccnt <= 4; end
        C_BUSY: if (ccnt == 0) cst <= C_DONE; else ccnt <= ccnt - 1;
        default: if (encryption_start) cst <= C_IDLE;
      endcase
    end
  end
  assign encryption_ready = (cst == C_DONE);
  assign cipher_text = fake_ct(plain_text);
  assign tag = fake_tag(key, nonce, associated_data);

  // Result monitor: pops the scoreboard on every completed result handshake.
  always @(negedge clk) begin
    res_t e;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("res_ct", res_ct, e.ct);
        check("res_tag", res_tag, e.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_request(input logic [127:0] k, input logic [127:0] n,
                             input logic [L-1:0] a, input logic [Y-1:0] p, input int hold);
    logic [W*64-1:0] eb;
    logic [Y-1:0] ct_held;
    logic [127:0] tag_held;
    int cyc;
    eb = '0;
    for (int j = 0; j < W; j++) begin
      m_lane0 = ref_step(m_lane0);
      eb = {eb[W*64-65:0], m_lane0};
    end
    req_key = k; req_nonce = n; req_ad = a; req_pt = p; req_valid = 1'b1;
    #1;
    check("req_ready_accept", req_ready, 1'b1);
    exp_q.push_back('{ct: fake_ct(p), tag: fake_tag(k, n, a)});
    tick();
    req_valid = 1'b0;
    #1;
    check("latched_key", key, k);
    check("latched_nonce", nonce, n);
    check("latched_ad", associated_data, a);
    check("latched_pt", plain_text, p);
    check("req_ready_fill", req_ready, 1'b0);
    cyc = 1;
    while (!encryption_start && cyc < 40) begin
      tick();
      cyc++;
    end
    check("start_latency", cyc, 12);
    check("share_key_1", random_key_1, eb[703 -: 128]);
    check("share_key_2", random_key_2, eb[575 -: 128]);
    check("share_nonce_1", random_nonce_1, eb[447 -: 128]);
    check("share_nonce_2", random_nonce_2, eb[319 -: 128]);
    check("share_ad_1", random_ad_1, eb[191 -: 40]);
    check("share_ad_2", random_ad_2, eb[151 -: 40]);
    check("share_pt_1", random_pt_1, eb[111 -: 40]);
    check("share_pt_2", random_pt_2, eb[71 -: 40]);
    tick();
    check("start_pulse_width", encryption_start, 1'b0);
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check("res_valid_seen", res_valid, 1'b1);
    check("share_key_1_held", random_key_1, eb[703 -: 128]);
    check("share_pt_2_held", random_pt_2, eb[71 -: 40]);
    ct_held = res_ct;
    tag_held = res_tag;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_res_valid", res_valid, 1'b1);
      check("hold_res_ct", res_ct, ct_held);
      check("hold_res_tag", res_tag, tag_held);
      check("hold_req_ready", req_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    check("res_valid_drop", res_valid, 1'b0);
    check("ready_after_result", req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Test 1: reset, then unseeded with a pending request.
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", any_out, 1'b0);
    rst = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("unseeded_req_ready", req_ready, 1'b0);
      check("unseeded_start", encryption_start, 1'b0);
      check("unseeded_r", |{r0, r1, r2, r3, r4, r5, r6}, 1'b0);
    end
    req_valid = 1'b0;

    // Test 2: zero seed, lane 0 starts at C0, golden share stream and latency.
    seed = 64'h0;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    m_lane0 = ref_init(64'h0, 0);
    check("seed_r0", r0, ref_const(1));
    check("seed_r6", r6, ref_const(7));
    tick();
    check("step_r0", r0, ref_step(ref_const(1)));
    run_request(128'h000102030405060708090A0B0C0D0E0F,
                128'h000102030405060708090A0B0C0D0E0F,
                40'h0001020304, 40'h0001020304, 0);

    // Test 3: second request continues the lane-0 stream.
    run_request(128'h0F0E0D0C0B0A09080706050403020100,
                128'hFFEEDDCCBBAA99887766554433221100,
                40'hA1B2C3D4E5, 40'h1122334455, 0);

    // Test 4: simultaneous reseed and request; seed equal to C2 hits the zero fallback.
    seed = ref_const(2);
    seed_valid = 1'b1;
    req_key = 128'h0123456789ABCDEF0011223344556677;
    req_valid = 1'b1;
    #1;
    check("reseed_blocks_req", req_ready, 1'b0);
    tick();
    seed_valid = 1'b0;
    m_lane0 = ref_init(ref_const(2), 0);
    check("reseed_r1_fallback", r1, ref_const(2));
    check("reseed_r0", r0, ref_const(2) ^ ref_const(1));
    check("reseed_not_accepted", key, 128'h0F0E0D0C0B0A09080706050403020100);

    // Test 5: accepted next cycle, result held 10 cycles under backpressure.
    run_request(128'h0123456789ABCDEF0011223344556677,
                128'h8899AABBCCDDEEFF0102030405060708,
                40'hFFFFFFFFFF, 40'h0000000000, 10);

    // Test 6: reset in cycle 5 of FILL aborts everything.
    req_key = 128'hDEADBEEF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    check("fill_in_progress", key, 128'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outputs", any_out, 1'b0);
    req_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("abort_no_start", encryption_start, 1'b0);
      check("abort_unseeded", req_ready, 1'b0);
    end
    req_valid = 1'b0;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_share_ctrl.md
Name: ascon_share_ctrl

Overview:
- Upstream front-end and result collector for the threshold-implementation (3-share) Ascon AEAD encryption core.
- Accepts a key/nonce/AD/PT request over a valid/ready handshake and holds it stable for the whole encryption.
- Generates the masking shares (random_key_1/2, random_nonce_1/2, random_ad_1/2, random_pt_1/2) and the per-cycle fresh randomness r0..r6 from on-chip xorshift64 lanes.
- Sequences encryption_start toward the core, then captures cipher_text and tag into a result register with its own valid/ready handshake.

Parameters:
- K, 128, key width; must match core k.
- L, 40, associated-data width; must match core l.
- Y, 40, plain-text width; must match core y.
- RB, 2*(K+128+L+Y), total share-random bits (derived; not overridable).
- W, ceil(RB/64), fill words (derived; 11 at defaults).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- seed_valid  in  1  load new PRNG seed
- seed  in  64  seed value
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_key  in  K  secret key
- req_nonce  in  128  nonce
- req_ad  in  L  associated data
- req_pt  in  Y  plain text
- key, nonce, associated_data, plain_text  out  K/128/L/Y  latched request to core
- random_key_1, random_key_2  out  K each  key shares
- random_nonce_1, random_nonce_2  out  128 each  nonce shares
- random_ad_1, random_ad_2  out  L each  AD shares
- random_pt_1, random_pt_2  out  Y each  PT shares
- r0..r6  out  64 each  fresh randomness to core, lanes 1..7
- encryption_start  out  1  start/acknowledge pulse to core
- encryption_ready  in  1  core done (combinational, high in core DONE)
- cipher_text  in  Y  from core
- tag  in  128  from core
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_ct  out  Y  captured cipher text
- res_tag  out  128  captured tag

Behaviour:
- One clock. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; seeded=0; state UNSEEDED; lane i state = C_i.
- Reset mid-operation aborts immediately; the core shares rst.
- PRNG lanes 0..7: xorshift64 step x^=x<<13; x^=x>>7; x^=x<<17.
- Seeding: on seed accept, lane i <= seed^C_i; if that value is 0, lane i <= C_i. Sets seeded=1.
- Lanes 1..7 step every cycle while seeded. r(i-1) = lane i state (registered).
- Lane 0 steps only in FILL.
- FSM states: UNSEEDED, READY, FILL, START, BUSY, RELEASE, RESULT.
- UNSEEDED: req_ready=0. seed_valid -> READY.
- READY:
  - seed_valid accepted (reseed) and has priority: req_ready=0 in that cycle.
  - Otherwise req_ready=1. On req_valid, latch req_* into key/nonce/associated_data/plain_text, clear fill_ctr, go FILL.
- FILL: W cycles.
  - Each cycle lane 0 steps; share buffer (W*64 bits) <= {buf << 64} with the new lane-0 state in bits [63:0].
  - fill_ctr counts 0..W-1; at W-1 -> START.
- Buffer map, MSB first: random_key_1, random_key_2, random_nonce_1, random_nonce_2, random_ad_1, random_ad_2, random_pt_1, random_pt_2; low W*64-RB bits unused.
- Share outputs change only in FILL and are stable from START until the next FILL.
- START: encryption_start=1 for exactly one cycle -> BUSY.
- BUSY:
  - encryption_start=0.
  - When encryption_ready=1: res_ct<=cipher_text, res_tag<=tag, go RELEASE.
  - No timeout.
- RELEASE: encryption_start=1 for one cycle (returns core DONE->IDLE) -> RESULT.
- RESULT: res_valid=1; res_ct/res_tag held. On res_ready -> READY (res_valid=0 next cycle).
- seed_valid outside UNSEEDED/READY is ignored.
- req_ready=0 outside READY.
- Latency: accept to first start pulse = W+1 cycles (start asserted in cycle W+1 after the accept edge).

Decomposition:
- Package ascon_share_pkg: state encoding; lane constants C_0..C_7, with C_0=64'h9E3779B97F4A7C15, C_i = C_0 rotated left by 8*i; xorshift64 step function; derived RB/W formulas.
- One sub-module, ascon_xorshift_lane: 64-bit state, seed load, step enable, exposes state.

Test Plan:
1. rst held, then released, no seed -> req_ready=0, encryption_start=0, r0..r6=0 for 20 cycles even with req_valid=1.
2. seed=0, then request -> lane 0 starts at C_0; buffer words equal the golden xorshift sequence from C_0; encryption_start high exactly at cycle 12 after the accept edge (W=11).
3. Full run with reference core, key=000102..0F, nonce=000102..0F, AD=0x0001020304, PT=0x0001020304 -> res_ct/res_tag match the Ascon-128a KAT; the XOR of each share triple equals the inputs; shares constant from START through RELEASE.
4. Simultaneous seed_valid and req_valid in READY -> seed taken, req_ready=0 that cycle, request accepted on the following cycle.
5. res_ready held 0 for 10 cycles in RESULT -> res_valid and res_ct/res_tag stable, req_ready=0; res_ready=1 -> READY next cycle.
6. rst asserted in cycle 5 of FILL -> next cycle all outputs 0, state UNSEEDED, encryption_start never pulsed.
